// File: rtl/data_array_port_ctrl_pkg.sv
// Shared definitions for the data array port controller.
//   - default geometry of the 2-lane x 32-bit data array
//   - FSM state encoding
//   - lane-mask-all-ones constant used by the zero-initialisation sweep
package data_array_port_ctrl_pkg;

  localparam int ADDR_W_DEF    = 11;
  localparam int LANE_W_DEF    = 32;
  localparam int LANES_DEF     = 2;
  localparam int RSP_DEPTH_DEF = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [LANES_DEF-1:0] MASK_ALL = '1;

endpackage

// File: rtl/data_array_port_ctrl_if.sv
// Request/response handshake bundle between the cache pipeline and the
// data array port controller.
//   req_*  : valid/ready request channel (read or masked write)
//   rsp_*  : valid/ready read-response channel
// master = cache pipeline side, slave = controller side.
interface data_array_port_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64,
  parameter int LANES  = 2
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LANES-1:0]  req_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/data_array_rsp_queue.sv
// Small FIFO holding captured read data until the consumer takes it.
//   clock, reset_n : clock and async active-low reset (pointers/count only)
//   push, push_data: enqueue one entry (caller guarantees space)
//   pop            : dequeue head entry; ignored when empty
//   pop_data       : head entry, stable until popped
//   count          : current occupancy
//   not_empty      : count != 0
module data_array_rsp_queue #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             not_empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;

  assign pop_ok    = pop && (count_q != '0);
  assign pop_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign not_empty = (count_q != '0);

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_array_port_ctrl.sv
// Requester-side controller for the single-port (RW0) data array.
//   clock, reset_n : clock (also the array clock), async active-low reset
//   bus            : request/response handshake (slave side)
//   init_done      : high once the zero-initialisation sweep has finished
//   arr_*          : array RW0 port; arr_rdata valid the cycle after a read
// After reset every entry is written with zero, then valid/ready requests are
// passed straight through to the array. Read data returns one cycle later
// and is captured into a response queue; request credits guarantee room.
module data_array_port_ctrl
  import data_array_port_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LANE_W    = LANE_W_DEF,
  parameter int LANES     = LANES_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  data_array_port_ctrl_if.slave   bus,
  output logic                    init_done,
  output logic                    arr_en,
  output logic                    arr_wmode,
  output logic [ADDR_W-1:0]       arr_addr,
  output logic [LANES*LANE_W-1:0] arr_wdata,
  output logic [LANES-1:0]        arr_wmask,
  input  logic [LANES*LANE_W-1:0] arr_rdata
);

  localparam int DATA_W = LANES * LANE_W;
  localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
  localparam int USE_W  = CNT_W + 1;
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state_q, state_d;
  logic              armed_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              inflight_q;
  logic              req_ready;
  logic              accept;
  logic              rd_accept;
  logic [CNT_W-1:0]  q_count;
  logic [USE_W-1:0]  used;
  logic              rsp_pop;

  // armed_q keeps the array idle in the first cycle out of reset so the
  // port shows en=0/wmode=0 while reset is asserted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= 1'b1;
      inflight_q <= rd_accept;
      if (state_q == ST_INIT && armed_q && cnt_q != CNT_LAST)
        cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  // Credits count both queued data and the read whose data is still on its
  // way from the array; only registered state feeds req_ready.
  assign used = USE_W'(q_count) + USE_W'(inflight_q);

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    rd_accept = 1'b0;
    arr_en    = 1'b0;
    arr_wmode = 1'b0;
    arr_addr  = bus.req_addr;
    arr_wdata = bus.req_wdata;
    arr_wmask = '0;
    case (state_q)
      ST_INIT: begin
        arr_en    = armed_q;
        arr_wmode = armed_q;
        arr_addr  = cnt_q;
        arr_wdata = '0;
        arr_wmask = '1;
        if (armed_q && cnt_q == CNT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        req_ready = (used < USE_W'(RSP_DEPTH));
        accept    = bus.req_valid && req_ready;
        rd_accept = accept && !bus.req_write;
        arr_en    = accept;
        arr_wmode = accept && bus.req_write;
        if (accept && bus.req_write) arr_wmask = bus.req_mask;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.req_ready = req_ready;
  assign init_done     = (state_q == ST_RUN);
  assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;

  data_array_rsp_queue #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (arr_rdata),
    .pop       (rsp_pop),
    .pop_data  (bus.rsp_rdata),
    .count     (q_count),
    .not_empty (bus.rsp_valid)
  );

endmodule
